// File: rtl/lsp_quant_pkg.sv
// Shared LSP quantizer constants, build FSM states and codebook row addressing.
package lsp_quant_pkg;

    localparam int M   = 10;
    localparam int NC  = 5;
    localparam int NC0 = 128;
    localparam int NC1 = 32;

    localparam logic [15:0] GAP1 = 16'd10;
    localparam logic [15:0] GAP2 = 16'd5;

    localparam logic [11:0] LSPCB1_BASE = 12'd0;
    localparam logic [11:0] LSPCB2_BASE = 12'd1280;
    localparam logic [10:0] BUF_ADDR    = 11'd0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_SUM,
        S_EXP_D,
        S_EXP_A,
        S_EXP_B,
        S_WR,
        S_DONE
    } state_t;

    // Codebook rows are M words wide; all sums stay within 12 bits for legal rows.
    function automatic logic [11:0] cb_addr(input logic [11:0] base,
                                            input logic [6:0]  row,
                                            input logic [3:0]  j);
        return base + 12'(row) * 12'd10 + 12'(j);
    endfunction

endpackage

// File: rtl/lsp_expand_1_2_step.sv
// One j-step of the Lsp_expand_1_2 spacing correction: diff (EXP_D), tmp and
// saturating sub of buf[j-1] (EXP_A), saturating add into buf[j] (EXP_B).
module lsp_expand_1_2_step
    import lsp_quant_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  state_t      state,
    input  logic [15:0] gap,
    input  logic [15:0] prev,
    input  logic [15:0] cur,
    input  logic [15:0] sub_res,
    input  logic [15:0] add_res,
    output logic [15:0] sub_a,
    output logic [15:0] sub_b,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        wr_prev,
    output logic        wr_cur,
    output logic [15:0] prev_new,
    output logic [15:0] cur_new
);

    logic [15:0] diff;
    logic [15:0] tmp;
    logic [15:0] tmp_q;

    // Valid only in EXP_A, where the add unit carries diff + gap.
    assign tmp = $signed(add_res) >>> 1;

    always_comb begin
        sub_a    = 16'd0;
        sub_b    = 16'd0;
        add_a    = 16'd0;
        add_b    = 16'd0;
        wr_prev  = 1'b0;
        wr_cur   = 1'b0;
        prev_new = 16'd0;
        cur_new  = 16'd0;
        case (state)
            S_EXP_D: begin
                sub_a = prev;
                sub_b = cur;
            end
            S_EXP_A: begin
                add_a    = diff;
                add_b    = gap;
                sub_a    = prev;
                sub_b    = tmp;
                wr_prev  = !tmp[15] && (tmp != 16'd0);
                prev_new = sub_res;
            end
            S_EXP_B: begin
                add_a   = cur;
                add_b   = tmp_q;
                wr_cur  = !tmp_q[15] && (tmp_q != 16'd0);
                cur_new = add_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff  <= 16'd0;
            tmp_q <= 16'd0;
        end else begin
            if (state == S_EXP_D) diff  <= sub_res;
            if (state == S_EXP_A) tmp_q <= tmp;
        end
    end

endmodule

// File: rtl/lsp_get_quant_build.sv
// Rebuilds buf[0..9] from lspcb1/lspcb2 rows, applies the expand correction and writes it out.
// LSP_GET_QUANT_GAP2_EN adds a second expand pass with GAP2 before the write-out.
module lsp_get_quant_build
    import lsp_quant_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(NC0)-1:0]   code0,
    input  logic [$clog2(NC1)-1:0]   code1,
    input  logic [$clog2(NC1)-1:0]   code2,
    output logic                     done,
    output logic [11:0]              constMemAddr,
    input  logic [31:0]              constMemIn,
    output logic                     memWriteEn,
    output logic [10:0]              memWriteAddr,
    output logic [31:0]              memOut,
    output logic [15:0]              addOutA,
    output logic [15:0]              addOutB,
    input  logic [15:0]              addIn,
    output logic [15:0]              subOutA,
    output logic [15:0]              subOutB,
    input  logic [15:0]              subIn
);

    state_t      state;
    logic [3:0]  j;
    logic [3:0]  j_prev;
    logic [6:0]  c0;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [15:0] a;
    logic [15:0] lsp_buf [M];
    logic [15:0] gap;

    logic [15:0] step_add_a, step_add_b;
    logic        wr_prev, wr_cur;
    logic [15:0] prev_new, cur_new;

    // Tables carry Q13 values in the low half only.
    logic        unused_hi;
    assign unused_hi = ^constMemIn[31:16];

    assign j_prev = j - 4'd1;

`ifdef LSP_GET_QUANT_GAP2_EN
    logic pass2;
    assign gap = pass2 ? GAP2 : GAP1;
`else
    assign gap = GAP1;
`endif

    lsp_expand_1_2_step u_step (
        .clk      (clk),
        .rst      (reset),
        .state    (state),
        .gap      (gap),
        .prev     (lsp_buf[j_prev]),
        .cur      (lsp_buf[j]),
        .sub_res  (subIn),
        .add_res  (addIn),
        .sub_a    (subOutA),
        .sub_b    (subOutB),
        .add_a    (step_add_a),
        .add_b    (step_add_b),
        .wr_prev  (wr_prev),
        .wr_cur   (wr_cur),
        .prev_new (prev_new),
        .cur_new  (cur_new)
    );

    always_comb begin
        constMemAddr = 12'd0;
        addOutA      = step_add_a;
        addOutB      = step_add_b;
        memWriteEn   = 1'b0;
        memWriteAddr = 11'd0;
        memOut       = 32'd0;
        done         = 1'b0;
        case (state)
            S_RD1: constMemAddr = cb_addr(LSPCB1_BASE, c0, j);
            S_RD2: constMemAddr = cb_addr(LSPCB2_BASE, {2'b00, (j < 4'(NC)) ? c1 : c2}, j);
            S_SUM: begin
                addOutA = a;
                addOutB = constMemIn[15:0];
            end
            S_WR: begin
                memWriteEn   = 1'b1;
                memWriteAddr = BUF_ADDR + 11'(j);
                memOut       = {{16{lsp_buf[j][15]}}, lsp_buf[j]};
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            j     <= 4'd0;
            c0    <= 7'd0;
            c1    <= 5'd0;
            c2    <= 5'd0;
            a     <= 16'd0;
            for (int k = 0; k < M; k++) lsp_buf[k] <= 16'd0;
`ifdef LSP_GET_QUANT_GAP2_EN
            pass2 <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    c0    <= code0;
                    c1    <= code1;
                    c2    <= code2;
                    j     <= 4'd0;
                    state <= S_RD1;
`ifdef LSP_GET_QUANT_GAP2_EN
                    pass2 <= 1'b0;
`endif
                end
                S_RD1: state <= S_RD2;
                S_RD2: begin
                    a     <= constMemIn[15:0];
                    state <= S_SUM;
                end
                S_SUM: begin
                    lsp_buf[j] <= addIn;
                    if (j < 4'(M - 1)) begin
                        j     <= j + 4'd1;
                        state <= S_RD1;
                    end else begin
                        j     <= 4'd1;
                        state <= S_EXP_D;
                    end
                end
                S_EXP_D: state <= S_EXP_A;
                S_EXP_A: begin
                    if (wr_prev) lsp_buf[j_prev] <= prev_new;
                    state <= S_EXP_B;
                end
                // EXP_B always runs so latency does not depend on the data.
                S_EXP_B: begin
                    if (wr_cur) lsp_buf[j] <= cur_new;
                    if (j < 4'(M - 1)) begin
                        j     <= j + 4'd1;
                        state <= S_EXP_D;
                    end else begin
`ifdef LSP_GET_QUANT_GAP2_EN
                        if (!pass2) begin
                            pass2 <= 1'b1;
                            j     <= 4'd1;
                            state <= S_EXP_D;
                        end else begin
                            j     <= 4'd0;
                            state <= S_WR;
                        end
`else
                        j     <= 4'd0;
                        state <= S_WR;
`endif
                    end
                end
                S_WR: begin
                    if (j == 4'(M - 1)) begin
                        state <= S_DONE;
                    end else begin
                        j <= j + 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
